// File: rtl/token_drop_engine.sv
// rtl/token_drop_engine.sv - gravity-drop engine for a COLS x ROWS connect-style board
// One drop/undo request at a time; board maps update on entry to RESP, while done is high.
module token_drop_engine #(
  parameter int COLS  = 4,
  parameter int ROWS  = 4,
  parameter int COL_W = 3
) (
  input  logic                            i_clk,
  input  logic                            i_reset_n,
  input  logic                            i_clear,
  input  logic                            i_drop_valid,
  input  logic [COL_W-1:0]                i_drop_col,
  input  logic                            i_drop_player,
  input  logic                            i_undo_valid,
  output logic                            o_req_ready,
  output logic                            o_done,
  output logic [2:0]                      o_status,
  output logic [$clog2(COLS*ROWS)-1:0]    o_cell_index,
  output logic [COLS*ROWS-1:0]            o_occupied,
  output logic [COLS*ROWS-1:0]            o_owner,
  output logic                            o_next_player,
  output logic                            o_board_full
);
  localparam int CELLS = COLS * ROWS;
  localparam int IDX_W = $clog2(CELLS);
  localparam int H_W   = $clog2(ROWS + 1);
  localparam int T_W   = $clog2(CELLS + 1);

  localparam logic [2:0] ST_OK         = 3'b000;
  localparam logic [2:0] ST_BAD_COL    = 3'b001;
  localparam logic [2:0] ST_COL_FULL   = 3'b010;
  localparam logic [2:0] ST_WRONG_TURN = 3'b011;
  localparam logic [2:0] ST_NO_UNDO    = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_RESP} state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [COL_W-1:0]   r_col;
  logic               r_player;
  logic               r_undo_mode;
  logic [H_W-1:0]     r_heights [COLS];
  logic [T_W-1:0]     r_total;
  logic [CELLS-1:0]   r_occ;
  logic [CELLS-1:0]   r_own;
  logic               r_next_player;
  logic               r_undo_valid;
  logic [COL_W-1:0]   r_undo_col;
  logic [IDX_W-1:0]   r_undo_idx;
  logic [2:0]         r_status;
  logic [IDX_W-1:0]   r_cell_index;

  logic [H_W-1:0]     w_height;
  logic [IDX_W-1:0]   w_drop_idx;
  logic [IDX_W-1:0]   w_idx;
  logic [2:0]         w_status;
  logic               w_ok;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    o_req_ready  = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_drop_valid || i_undo_valid) w_next_state = S_EVAL;
      end
      S_EVAL: w_next_state = S_RESP;
      S_RESP: begin
        o_done       = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
    if (i_clear) w_next_state = S_IDLE;
  end

  // Height of the captured column; out-of-range codes read as 0 but are rejected anyway.
  always_comb begin
    w_height = '0;
    for (int c = 0; c < COLS; c++) begin
      if (r_col == COL_W'(c)) w_height = r_heights[c];
    end
    w_drop_idx = IDX_W'(w_height) * IDX_W'(COLS) + IDX_W'(r_col);
    w_ok       = 1'b0;
    w_status   = ST_OK;
    w_idx      = w_drop_idx;
    if (r_undo_mode) begin
      w_idx = r_undo_idx;
      if (r_undo_valid) w_ok = 1'b1;
      else              w_status = ST_NO_UNDO;
    end else if (r_col >= COL_W'(COLS)) begin
      w_status = ST_BAD_COL;
    end else if (r_player != r_next_player) begin
      w_status = ST_WRONG_TURN;
    end else if (w_height == H_W'(ROWS)) begin
      w_status = ST_COL_FULL;
    end else begin
      w_ok = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_col         <= '0;
      r_player      <= 1'b0;
      r_undo_mode   <= 1'b0;
      r_total       <= '0;
      r_occ         <= '0;
      r_own         <= '0;
      r_next_player <= 1'b0;
      r_undo_valid  <= 1'b0;
      r_undo_col    <= '0;
      r_undo_idx    <= '0;
      r_status      <= ST_OK;
      r_cell_index  <= '0;
      for (int c = 0; c < COLS; c++) r_heights[c] <= '0;
    end else if (i_clear) begin
      r_undo_mode   <= 1'b0;
      r_total       <= '0;
      r_occ         <= '0;
      r_own         <= '0;
      r_next_player <= 1'b0;
      r_undo_valid  <= 1'b0;
      r_undo_col    <= '0;
      r_undo_idx    <= '0;
      for (int c = 0; c < COLS; c++) r_heights[c] <= '0;
    end else begin
      if (r_state == S_IDLE) begin
        if (i_drop_valid) begin
          r_col       <= i_drop_col;
          r_player    <= i_drop_player;
          r_undo_mode <= 1'b0;
        end else if (i_undo_valid) begin
          r_undo_mode <= 1'b1;
        end
      end
      if (r_state == S_EVAL) begin
        r_status     <= w_status;
        r_cell_index <= w_ok ? w_idx : '0;
        if (w_ok) begin
          r_next_player <= ~r_next_player;
          if (r_undo_mode) begin
            r_occ[r_undo_idx] <= 1'b0;
            r_own[r_undo_idx] <= 1'b0;
            r_total           <= r_total - T_W'(1);
            r_undo_valid      <= 1'b0;
            for (int c = 0; c < COLS; c++) begin
              if (r_undo_col == COL_W'(c)) r_heights[c] <= r_heights[c] - H_W'(1);
            end
          end else begin
            r_occ[w_drop_idx] <= 1'b1;
            r_own[w_drop_idx] <= r_player;
            r_total           <= r_total + T_W'(1);
            r_undo_valid      <= 1'b1;
            r_undo_col        <= r_col;
            r_undo_idx        <= w_drop_idx;
            for (int c = 0; c < COLS; c++) begin
              if (r_col == COL_W'(c)) r_heights[c] <= r_heights[c] + H_W'(1);
            end
          end
        end
      end
    end
  end

  assign o_status      = r_status;
  assign o_cell_index  = r_cell_index;
  assign o_occupied    = r_occ;
  assign o_owner       = r_own;
  assign o_next_player = r_next_player;
  assign o_board_full  = (r_total == T_W'(CELLS));

endmodule

// File: tb/tb_token_drop_engine.sv
// tb/tb_token_drop_engine.sv - self-checking bench for token_drop_engine (4x4 and 7x6 instances)
module tb_token_drop_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        dv [2];
  logic        uv [2];
  logic        pl [2];
  logic        clr [2];
  logic [2:0]  col [2];
  logic        rdy [2];
  logic        dn [2];
  logic        nxt [2];
  logic        full [2];
  logic [2:0]  st [2];
  logic [3:0]  ci4;
  logic [5:0]  ci7;
  logic [15:0] occ4, own4;
  logic [41:0] occ7, own7;
  logic [63:0] ci [2];
  logic [63:0] occ [2];
  logic [63:0] own [2];

  assign ci[0]  = 64'(ci4);
  assign ci[1]  = 64'(ci7);
  assign occ[0] = 64'(occ4);
  assign occ[1] = 64'(occ7);
  assign own[0] = 64'(own4);
  assign own[1] = 64'(own7);

  token_drop_engine #(.COLS(4), .ROWS(4), .COL_W(3)) dut4 (
    .i_clk(clk), .i_reset_n(rst_n), .i_clear(clr[0]), .i_drop_valid(dv[0]),
    .i_drop_col(col[0]), .i_drop_player(pl[0]), .i_undo_valid(uv[0]),
    .o_req_ready(rdy[0]), .o_done(dn[0]), .o_status(st[0]), .o_cell_index(ci4),
    .o_occupied(occ4), .o_owner(own4), .o_next_player(nxt[0]), .o_board_full(full[0])
  );

  token_drop_engine #(.COLS(7), .ROWS(6), .COL_W(3)) dut7 (
    .i_clk(clk), .i_reset_n(rst_n), .i_clear(clr[1]), .i_drop_valid(dv[1]),
    .i_drop_col(col[1]), .i_drop_player(pl[1]), .i_undo_valid(uv[1]),
    .o_req_ready(rdy[1]), .o_done(dn[1]), .o_status(st[1]), .o_cell_index(ci7),
    .o_occupied(occ7), .o_owner(own7), .o_next_player(nxt[1]), .o_board_full(full[1])
  );

  int checks = 0;
  int errors = 0;

  // Reference board: column heights plus per-cell owner; occupancy follows from heights.
  int m_cols [2] = '{4, 7};
  int m_rows [2] = '{4, 6};
  int m_h    [2][8];
  int m_cell [2][64];
  bit m_next [2];
  bit m_uv   [2];
  int m_ucol [2];

  function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endfunction

  function automatic void m_clear(int s);
    for (int c = 0; c < 8; c++) m_h[s][c] = 0;
    m_next[s] = 1'b0;
    m_uv[s]   = 1'b0;
    m_ucol[s] = 0;
  endfunction

  function automatic void m_req(int s, bit d, bit u, int c, bit p, output int est, output int eidx);
    est  = 0;
    eidx = 0;
    if (d) begin
      if (c >= m_cols[s])              est = 1;
      else if (p != m_next[s])         est = 3;
      else if (m_h[s][c] == m_rows[s]) est = 2;
      else begin
        eidx = m_h[s][c] * m_cols[s] + c;
        m_cell[s][eidx] = int'(p);
        m_h[s][c]++;
        m_next[s] = !m_next[s];
        m_uv[s]   = 1'b1;
        m_ucol[s] = c;
      end
    end else if (u) begin
      if (!m_uv[s]) est = 4;
      else begin
        m_h[s][m_ucol[s]]--;
        eidx = m_h[s][m_ucol[s]] * m_cols[s] + m_ucol[s];
        m_next[s] = !m_next[s];
        m_uv[s]   = 1'b0;
      end
    end
  endfunction

  function automatic logic [63:0] m_occ(int s);
    logic [63:0] v = '0;
    for (int c = 0; c < m_cols[s]; c++)
      for (int r = 0; r < m_h[s][c]; r++) v[r * m_cols[s] + c] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] m_own(int s);
    logic [63:0] v = '0;
    for (int c = 0; c < m_cols[s]; c++)
      for (int r = 0; r < m_h[s][c]; r++) v[r * m_cols[s] + c] = m_cell[s][r * m_cols[s] + c][0];
    return v;
  endfunction

  function automatic bit m_full(int s);
    int t = 0;
    for (int c = 0; c < m_cols[s]; c++) t += m_h[s][c];
    return t == m_cols[s] * m_rows[s];
  endfunction

  function automatic void check_maps(int s, string tag);
    chk({tag, ".occupied"}, occ[s], m_occ(s));
    chk({tag, ".owner"}, own[s] & occ[s], m_own(s));
    chk({tag, ".next_player"}, 64'(nxt[s]), 64'(m_next[s]));
    chk({tag, ".board_full"}, 64'(full[s]), 64'(m_full(s)));
  endfunction

  function automatic void check_reset(int s, string tag);
    chk({tag, ".req_ready"}, 64'(rdy[s]), 64'd1);
    chk({tag, ".done"}, 64'(dn[s]), 64'd0);
    chk({tag, ".status"}, 64'(st[s]), 64'd0);
    chk({tag, ".cell_index"}, ci[s], 64'd0);
    check_maps(s, tag);
  endfunction

  // Called at a negedge; returns with the bench again at a negedge after the response.
  task automatic req(input int s, input bit d, input bit u, input int c, input bit p,
                     output int gst, output int gidx, output bit gdone);
    int n = 0;
    while (!rdy[s] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", 64'(rdy[s]), 64'd1);
    dv[s] = d; uv[s] = u; col[s] = c[2:0]; pl[s] = p;
    @(posedge clk);
    #1;
    dv[s] = 1'b0; uv[s] = 1'b0; col[s] = 3'($urandom); pl[s] = 1'($urandom);
    @(negedge clk);
    chk("done_early", 64'(dn[s]), 64'd0);
    @(negedge clk);
    gdone = dn[s];
    gst   = int'(st[s]);
    gidx  = int'(ci[s]);
    @(negedge clk);
    chk("done_width", 64'(dn[s]), 64'd0);
    chk("ready_after_done", 64'(rdy[s]), 64'd1);
  endtask

  task automatic run_req(input int s, input bit d, input bit u, input int c, input bit p,
                         input string tag, output int gst, output int gidx);
    int est, eidx;
    bit gdone;
    m_req(s, d, u, c, p, est, eidx);
    req(s, d, u, c, p, gst, gidx, gdone);
    chk({tag, ".done"}, 64'(gdone), 64'd1);
    chk({tag, ".status"}, 64'(gst), 64'(est));
    chk({tag, ".cell_index"}, 64'(gidx), 64'(eidx));
    check_maps(s, tag);
  endtask

  task automatic do_clear(input int s);
    clr[s] = 1'b1;
    @(posedge clk);
    #1;
    clr[s] = 1'b0;
    m_clear(s);
    @(negedge clk);
    check_maps(s, "clear");
  endtask

  typedef struct {
    bit d;
    bit u;
    int c;
    bit p;
    int est;
    int eidx;
  } vec_t;

  initial begin
    vec_t tbl [13];
    int gst, gidx, r, c;
    bit p;

    tbl[0]  = '{1, 0, 2, 0, 0, 2};
    tbl[1]  = '{1, 0, 1, 1, 0, 1};
    tbl[2]  = '{1, 0, 1, 0, 0, 5};
    tbl[3]  = '{1, 0, 1, 1, 0, 9};
    tbl[4]  = '{1, 0, 1, 0, 0, 13};
    tbl[5]  = '{1, 0, 1, 1, 2, 0};
    tbl[6]  = '{1, 0, 5, 0, 1, 0};
    tbl[7]  = '{1, 0, 3, 0, 3, 0};
    tbl[8]  = '{1, 0, 3, 1, 0, 3};
    tbl[9]  = '{0, 1, 0, 0, 0, 3};
    tbl[10] = '{0, 1, 0, 0, 4, 0};
    tbl[11] = '{1, 0, 7, 1, 1, 0};
    tbl[12] = '{1, 0, 0, 1, 0, 0};

    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      dv[s] = 0; uv[s] = 0; pl[s] = 0; clr[s] = 0; col[s] = 0;
      m_clear(s);
    end
    repeat (3) @(negedge clk);
    check_reset(0, "reset4");
    check_reset(1, "reset7");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      run_req(0, tbl[i].d, tbl[i].u, tbl[i].c, tbl[i].p, $sformatf("tbl%0d", i), gst, gidx);
      chk($sformatf("tbl%0d.status_const", i), 64'(gst), 64'(tbl[i].est));
      chk($sformatf("tbl%0d.idx_const", i), 64'(gidx), 64'(tbl[i].eidx));
    end

    run_req(0, 1'b1, 1'b1, 2, m_next[0], "both_valid", gst, gidx);
    repeat (2) begin
      @(negedge clk);
      chk("both_valid.no_second_done", 64'(dn[0]), 64'd0);
    end
    run_req(0, 1'b0, 1'b1, 0, 1'b0, "undo_after_both", gst, gidx);

    dv[0] = 1'b1; col[0] = 3'd3; pl[0] = m_next[0];
    @(posedge clk);
    #1;
    dv[0] = 1'b0;
    clr[0] = 1'b1;
    @(posedge clk);
    #1;
    clr[0] = 1'b0;
    m_clear(0);
    repeat (3) begin
      @(negedge clk);
      chk("clear_eval.done", 64'(dn[0]), 64'd0);
    end
    check_maps(0, "clear_eval");

    run_req(0, 1'b1, 1'b0, 1, 1'b0, "pre_reset", gst, gidx);
    dv[0] = 1'b1; col[0] = 3'd2; pl[0] = m_next[0];
    @(posedge clk);
    #1;
    dv[0] = 1'b0;
    rst_n = 1'b0;
    m_clear(0);
    m_clear(1);
    @(negedge clk);
    check_reset(0, "reset_mid");
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("reset_mid.no_done", 64'(dn[0]), 64'd0);
    end

    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 99);
      c = $urandom_range(0, 7);
      p = ($urandom_range(0, 9) == 0) ? !m_next[0] : m_next[0];
      if (r < 5)       do_clear(0);
      else if (r < 20) run_req(0, 1'b0, 1'b1, c, p, "rnd4_undo", gst, gidx);
      else if (r < 23) run_req(0, 1'b1, 1'b1, c, p, "rnd4_both", gst, gidx);
      else             run_req(0, 1'b1, 1'b0, c, p, "rnd4_drop", gst, gidx);
    end

    for (int i = 0; i < 42; i++) begin
      run_req(1, 1'b1, 1'b0, i % 7, 1'(i % 2), "fill7", gst, gidx);
      chk($sformatf("fill7_%0d.idx", i), 64'(gidx), 64'(i));
      chk($sformatf("fill7_%0d.full", i), 64'(full[1]), 64'(i == 41));
    end
    run_req(1, 1'b1, 1'b0, 0, 1'b0, "drop43", gst, gidx);
    chk("drop43.status_const", 64'(gst), 64'd2);

    do_clear(1);
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 99);
      c = $urandom_range(0, 7);
      p = ($urandom_range(0, 9) == 0) ? !m_next[1] : m_next[1];
      if (r < 15) run_req(1, 1'b0, 1'b1, c, p, "rnd7_undo", gst, gidx);
      else        run_req(1, 1'b1, 1'b0, c, p, "rnd7_drop", gst, gidx);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
